// File: rtl/video_stream_monitor_if.sv
// Pixel stream bundle between the video output stage (master) and the monitor (slave).
// Latency: n/a (wires only).
// Backpressure: none; the stream advances one pixel per clock unconditionally.
interface video_stream_monitor_if;
  logic [3:0] vid_r;
  logic [3:0] vid_g;
  logic [3:0] vid_b;
  logic       vid_de;
  logic       vid_hsync;
  logic       vid_vsync;

  modport master (
    output vid_r, vid_g, vid_b, vid_de, vid_hsync, vid_vsync
  );

  modport slave (
    input  vid_r, vid_g, vid_b, vid_de, vid_hsync, vid_vsync
  );
endinterface

// File: rtl/video_stream_monitor.sv
// Frame timing / CRC monitor on the RGB444 output stream; results latched per frame for readback.
// Latency: frame_done and res_* update 2 clk after the vsync leading edge reaches the input pins.
// Backpressure: none, always accepts a pixel per clock. Optional line capture: VIDEO_MON_LINECAP_EN.
module video_stream_monitor #(
  parameter bit          HSYNC_ACT_LOW = 1'b1,
  parameter bit          VSYNC_ACT_LOW = 1'b1,
  parameter int          CNT_W         = 11,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  video_stream_monitor_if.slave vid,
  input  logic                 err_clr,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     res_htotal,
  output logic [CNT_W-1:0]     res_vtotal,
  output logic [CNT_W-1:0]     res_width,
  output logic [CNT_W-1:0]     res_height,
  output logic [15:0]          res_crc,
  output logic                 locked,
  output logic                 err_linelen
`ifdef VIDEO_MON_LINECAP_EN
  ,
  input  logic [CNT_W-1:0]     cap_line,
  input  logic [8:0]           cap_addr,
  output logic [11:0]          cap_rddata
`endif
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // CRC-16-CCITT (poly 0x1021), MSB-first over one 12-bit pixel.
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  state_e state_q, state_d;

  // Input stage
  logic [11:0] pix_q, pix_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic de_prev_q, de_prev_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic hs_edge, vs_edge;

  // Frame accumulators
  logic [CNT_W-1:0] hcnt_q, hcnt_d, htot_q, htot_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0] run_q, run_d, width_q, width_d, height_q, height_d;
  logic hs_seen_q, hs_seen_d, width_set_q, width_set_d, line_de_q, line_de_d;
  logic [15:0] crc_q, crc_d;

  // Results
  logic frame_done_q, frame_done_d;
  logic [CNT_W-1:0] res_htotal_q, res_htotal_d, res_vtotal_q, res_vtotal_d;
  logic [CNT_W-1:0] res_width_q, res_width_d, res_height_q, res_height_d;
  logic [15:0] res_crc_q, res_crc_d;
  logic locked_q, locked_d, err_q, err_d, prev_vld_q, prev_vld_d;
  logic [1:0] match_cnt_q, match_cnt_d;
  logic [4*CNT_W-1:0] prev_q, prev_d, timing_now;

  // Per-cycle decode
  logic acc_en, frame_close, run_end, err_set, cur_line_de, new_line;
  logic [CNT_W-1:0] fin_width;

  // Register the raw stream once and normalise both syncs to active-high.
  always_comb begin
    pix_d     = {vid.vid_r, vid.vid_g, vid.vid_b};
    de_d      = vid.vid_de;
    hs_d      = HSYNC_ACT_LOW ? ~vid.vid_hsync : vid.vid_hsync;
    vs_d      = VSYNC_ACT_LOW ? ~vid.vid_vsync : vid.vid_vsync;
    de_prev_d = de_q;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
  end

  assign hs_edge = hs_q & ~hs_prev_q;
  assign vs_edge = vs_q & ~vs_prev_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: the first vsync edge only arms; later ones close a frame.
  always_comb begin
    state_d     = state_q;
    frame_close = 1'b0;
    acc_en      = vs_edge;
    case (state_q)
      ST_IDLE: if (vs_edge) state_d = ST_RUN;
      ST_RUN: begin
        acc_en      = 1'b1;
        frame_close = vs_edge;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame accumulators; a vsync edge cycle restarts them with that cycle's events included.
  always_comb begin
    hcnt_d      = hcnt_q;
    htot_d      = htot_q;
    vcnt_d      = vcnt_q;
    run_d       = run_q;
    width_d     = width_q;
    height_d    = height_q;
    hs_seen_d   = hs_seen_q;
    width_set_d = width_set_q;
    line_de_d   = line_de_q;
    crc_d       = crc_q;
    run_end     = 1'b0;
    err_set     = 1'b0;
    cur_line_de = 1'b0;
    new_line    = 1'b0;
    if (!acc_en) begin
      hcnt_d      = '0;
      htot_d      = '0;
      vcnt_d      = '0;
      run_d       = '0;
      width_d     = '0;
      height_d    = '0;
      hs_seen_d   = 1'b0;
      width_set_d = 1'b0;
      line_de_d   = 1'b0;
      crc_d       = CRC_INIT;
    end else begin
      // Line length: counter restarts at 1 on each hsync edge.
      hcnt_d = hs_edge ? ONE : sat_inc(hcnt_q);
      if (hs_edge) begin
        if (hs_seen_q) htot_d = hcnt_q;
        hs_seen_d = 1'b1;
        vcnt_d    = sat_inc(vcnt_q);
      end
      // DE runs: run_q still holds the finished run length on the falling cycle.
      run_end = de_prev_q & ~de_q;
      run_d   = de_q ? (de_prev_q ? sat_inc(run_q) : ONE) : '0;
      if (run_end) begin
        if (!width_set_q) begin
          width_d     = run_q;
          width_set_d = 1'b1;
        end else if (run_q != width_q) begin
          err_set = 1'b1;
        end
      end
      // A line counts toward height on its first DE cycle.
      cur_line_de = hs_edge ? 1'b0 : line_de_q;
      new_line    = de_q & ~cur_line_de;
      line_de_d   = cur_line_de | de_q;
      if (new_line) height_d = sat_inc(height_q);
      if (de_q) crc_d = crc12(crc_q, pix_q);
      // New frame: events of the edge cycle belong to it.
      if (vs_edge) begin
        htot_d      = '0;
        hs_seen_d   = hs_edge;
        vcnt_d      = hs_edge ? ONE : '0;
        run_d       = de_q ? ONE : '0;
        width_d     = '0;
        width_set_d = 1'b0;
        line_de_d   = de_q;
        height_d    = de_q ? ONE : '0;
        crc_d       = de_q ? crc12(CRC_INIT, pix_q) : CRC_INIT;
      end
    end
  end

  // Latch results at frame close, track lock, and keep the sticky line-length error.
  always_comb begin
    frame_done_d = 1'b0;
    res_htotal_d = res_htotal_q;
    res_vtotal_d = res_vtotal_q;
    res_width_d  = res_width_q;
    res_height_d = res_height_q;
    res_crc_d    = res_crc_q;
    locked_d     = locked_q;
    match_cnt_d  = match_cnt_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    // A run that ends on the edge cycle still belongs to the closing frame.
    fin_width    = width_set_q ? width_q : (run_end ? run_q : '0);
    timing_now   = {htot_q, vcnt_q, fin_width, height_q};
    err_d        = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    if (frame_close) begin
      frame_done_d = 1'b1;
      res_htotal_d = htot_q;
      res_vtotal_d = vcnt_q;
      res_width_d  = fin_width;
      res_height_d = height_q;
      res_crc_d    = crc_q;
      if (prev_vld_q && (timing_now == prev_q))
        match_cnt_d = (match_cnt_q == 2'd2) ? 2'd2 : match_cnt_q + 2'd1;
      else
        match_cnt_d = 2'd0;
      locked_d   = (match_cnt_d == 2'd2);
      prev_d     = timing_now;
      prev_vld_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hcnt_q       <= '0;
      htot_q       <= '0;
      vcnt_q       <= '0;
      run_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      hs_seen_q    <= 1'b0;
      width_set_q  <= 1'b0;
      line_de_q    <= 1'b0;
      crc_q        <= CRC_INIT;
      frame_done_q <= 1'b0;
      res_htotal_q <= '0;
      res_vtotal_q <= '0;
      res_width_q  <= '0;
      res_height_q <= '0;
      res_crc_q    <= '0;
      locked_q     <= 1'b0;
      match_cnt_q  <= 2'd0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pix_q        <= pix_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_prev_q    <= de_prev_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;
      htot_q       <= htot_d;
      vcnt_q       <= vcnt_d;
      run_q        <= run_d;
      width_q      <= width_d;
      height_q     <= height_d;
      hs_seen_q    <= hs_seen_d;
      width_set_q  <= width_set_d;
      line_de_q    <= line_de_d;
      crc_q        <= crc_d;
      frame_done_q <= frame_done_d;
      res_htotal_q <= res_htotal_d;
      res_vtotal_q <= res_vtotal_d;
      res_width_q  <= res_width_d;
      res_height_q <= res_height_d;
      res_crc_q    <= res_crc_d;
      locked_q     <= locked_d;
      match_cnt_q  <= match_cnt_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      err_q        <= err_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign res_htotal  = res_htotal_q;
  assign res_vtotal  = res_vtotal_q;
  assign res_width   = res_width_q;
  assign res_height  = res_height_q;
  assign res_crc     = res_crc_q;
  assign locked      = locked_q;
  assign err_linelen = err_q;

`ifdef VIDEO_MON_LINECAP_EN
  logic [11:0]      cap_mem_q [512];
  logic [11:0]      cap_rd_q;
  logic [CNT_W-1:0] base_h, cur_idx;
  logic [31:0]      pix_idx;
  logic             cap_we;
  logic [8:0]       cap_wa;

  // Select pixels of the requested active line; index within the run is the buffer address.
  always_comb begin
    base_h  = vs_edge ? '0 : height_q;
    cur_idx = new_line ? base_h : base_h - ONE;
    pix_idx = 32'(run_d) - 32'd1;
    cap_we  = acc_en && de_q && (cur_idx == cap_line) && (pix_idx < 32'd512);
    cap_wa  = pix_idx[8:0];
  end

  // Capture buffer with registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) cap_mem_q[i] <= '0;
      cap_rd_q <= '0;
    end else begin
      if (cap_we) cap_mem_q[cap_wa] <= pix_q;
      cap_rd_q <= cap_mem_q[cap_addr];
    end
  end

  assign cap_rddata = cap_rd_q;
`endif

endmodule
